mem_stage: RTL and testbench

Memory-access stage of the pipeline, directly upstream of the write-back stage. It takes the EX/MEM instruction and drives a single-port data memory through a valid/ready handshake. It generates byte enables and store-data lanes, and stalls the pipeline while memory is busy. It also owns the MEM/WB pipeline register that feeds write-back: load data is delivered lane-aligned, and write-back sign-extends it per `funct3`.

---
 rtl/mem_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory-access stage. Drives a valid/ready data memory,
//            stalls upstream while it waits, and owns the MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        flush,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        PC2Reg,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        wb_valid,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        PC2Reg_out,
    output logic [2:0]  funct3_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rd_data,
    output logic [31:0] Mem_out,
    output logic        misalign_err,
    output logic        dmem_timeout
);

    localparam int c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_squash;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_memread;
    logic              r_memtoreg;
    logic              r_regwrite;
    logic              r_pc2reg;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic [31:0]       r_alu;

    logic              w_idle;
    logic              w_mem_op;
    logic              w_misalign;
    logic              w_issue;
    logic              w_timeout_hit;
    logic [3:0]        w_st_be;
    logic [31:0]       w_st_data;
    logic [1:0]        w_off;
    logic [31:0]       w_load;

    logic              w_nx_valid;
    logic              w_nx_memtoreg;
    logic              w_nx_regwrite;
    logic              w_nx_pc2reg;
    logic [2:0]        w_nx_funct3;
    logic [4:0]        w_nx_rd;
    logic [31:0]       w_nx_rd_data;
    logic [31:0]       w_nx_mem;
    logic              w_nx_mis;
    logic              w_nx_to;

    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_mem_op   = valid_in & (MemRead | MemWrite) & ~flush;
        w_misalign = ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00)) |
                     ((funct3[1:0] == 2'b01) & alu_result[0]);
        w_issue    = w_idle & w_mem_op & ~w_misalign;
        w_timeout_hit = (TIMEOUT_CYCLES != 0) & ~w_idle & ~dmem_ready & (r_cnt == c_LIMIT);

        case (funct3[1:0])
            2'b00: begin
                w_st_be   = 4'b0001 << alu_result[1:0];
                w_st_data = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                w_st_be   = 4'b0011 << alu_result[1:0];
                w_st_data = {2{rs2_data[15:0]}};
            end
            default: begin
                w_st_be   = 4'b1111;
                w_st_data = rs2_data;
            end
        endcase

        w_off  = w_idle ? alu_result[1:0] : r_alu[1:0];
        w_load = dmem_rdata >> {w_off, 3'b000};
    end

    // Outputs toward memory come from the live instruction in IDLE and from
    // the captured copy in WAIT, so they stay stable while upstream is held.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_be    = 4'd0;
        stall_out  = 1'b0;
        if (!rst) begin
            if (w_idle) begin
                dmem_req = w_issue;
                if (w_issue) begin
                    dmem_we    = MemWrite;
                    dmem_addr  = {alu_result[31:2], 2'b00};
                    dmem_wdata = MemWrite ? w_st_data : 32'd0;
                    dmem_be    = MemWrite ? w_st_be : 4'b1111;
                end
            end else begin
                dmem_req   = 1'b1;
                dmem_we    = r_we;
                dmem_addr  = r_addr;
                dmem_wdata = r_wdata;
                dmem_be    = r_be;
            end
            stall_out = (w_issue & ~dmem_ready) | (~w_idle & ~dmem_ready & ~w_timeout_hit);
        end
    end

    always_comb begin
        w_nx_valid    = 1'b0;
        w_nx_memtoreg = 1'b0;
        w_nx_regwrite = 1'b0;
        w_nx_pc2reg   = 1'b0;
        w_nx_funct3   = 3'd0;
        w_nx_rd       = 5'd0;
        w_nx_rd_data  = 32'd0;
        w_nx_mem      = 32'd0;
        w_nx_mis      = 1'b0;
        w_nx_to       = 1'b0;
        if (w_idle) begin
            if (valid_in && !flush) begin
                w_nx_valid    = 1'b1;
                w_nx_memtoreg = MemtoReg;
                w_nx_regwrite = RegWrite & ~(w_mem_op & w_misalign);
                w_nx_pc2reg   = PC2Reg;
                w_nx_funct3   = funct3;
                w_nx_rd       = rd_in;
                w_nx_rd_data  = alu_result;
                w_nx_mem      = (w_issue & MemRead) ? w_load : 32'd0;
                w_nx_mis      = w_mem_op & w_misalign;
            end
        end else if (!(r_squash || flush)) begin
            // A squashed transaction still completes on the bus but retires as a bubble.
            w_nx_valid    = 1'b1;
            w_nx_memtoreg = r_memtoreg;
            w_nx_regwrite = r_regwrite & ~w_timeout_hit;
            w_nx_pc2reg   = r_pc2reg;
            w_nx_funct3   = r_funct3;
            w_nx_rd       = r_rd;
            w_nx_rd_data  = r_alu;
            w_nx_mem      = (r_memread & dmem_ready) ? w_load : 32'd0;
            w_nx_to       = w_timeout_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_squash     <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_memread    <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_pc2reg     <= 1'b0;
            r_funct3     <= 3'd0;
            r_rd         <= 5'd0;
            r_alu        <= 32'd0;
            wb_valid     <= 1'b0;
            MemtoReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            PC2Reg_out   <= 1'b0;
            funct3_out   <= 3'd0;
            rd_out       <= 5'd0;
            rd_data      <= 32'd0;
            Mem_out      <= 32'd0;
            misalign_err <= 1'b0;
            dmem_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue && !dmem_ready) begin
                        r_state    <= S_WAIT;
                        r_cnt      <= '0;
                        r_squash   <= 1'b0;
                        r_we       <= dmem_we;
                        r_addr     <= dmem_addr;
                        r_wdata    <= dmem_wdata;
                        r_be       <= dmem_be;
                        r_memread  <= MemRead;
                        r_memtoreg <= MemtoReg;
                        r_regwrite <= RegWrite;
                        r_pc2reg   <= PC2Reg;
                        r_funct3   <= funct3;
                        r_rd       <= rd_in;
                        r_alu      <= alu_result;
                    end
                end
                default: begin
                    if (dmem_ready || w_timeout_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt    <= r_cnt + c_CW'(1);
                        r_squash <= r_squash | flush;
                    end
                end
            endcase

            if (!stall_out) begin
                wb_valid     <= w_nx_valid;
                MemtoReg_out <= w_nx_memtoreg;
                RegWrite_out <= w_nx_regwrite;
                PC2Reg_out   <= w_nx_pc2reg;
                funct3_out   <= w_nx_funct3;
                rd_out       <= w_nx_rd;
                rd_data      <= w_nx_rd_data;
                Mem_out      <= w_nx_mem;
                misalign_err <= w_nx_mis;
                dmem_timeout <= w_nx_to;
            end else begin
                wb_valid     <= 1'b0;
                misalign_err <= 1'b0;
                dmem_timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Scoreboard bench for mem_stage with a scripted-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    typedef struct packed {
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        regwrite;
        logic        pc2reg;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rs2;
    } op_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        pc2reg;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic [31:0] mem_out;
        logic        mis;
        logic        to;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, flush;
    logic        MemRead, MemWrite, MemtoReg, RegWrite, PC2Reg;
    logic [2:0]  funct3;
    logic [4:0]  rd_in;
    logic [31:0] alu_result, rs2_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic        wb_valid, MemtoReg_out, RegWrite_out, PC2Reg_out;
    logic [2:0]  funct3_out;
    logic [4:0]  rd_out;
    logic [31:0] rd_data, Mem_out;
    logic        misalign_err, dmem_timeout;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    wb_t q_exp[$];
    wb_t r_got;

    mem_stage #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .PC2Reg(PC2Reg), .funct3(funct3), .rd_in(rd_in),
        .alu_result(alu_result), .rs2_data(rs2_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall_out(stall_out), .wb_valid(wb_valid),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .PC2Reg_out(PC2Reg_out), .funct3_out(funct3_out), .rd_out(rd_out),
        .rd_data(rd_data), .Mem_out(Mem_out), .misalign_err(misalign_err),
        .dmem_timeout(dmem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Retired MEM/WB entries are matched in order against the expected queue.
    always @(posedge clk) begin
        #1;
        if (!rst && (wb_valid || misalign_err || dmem_timeout)) begin
            if (q_exp.size() == 0) begin
                check("wb_unexpected", {29'd0, wb_valid, misalign_err, dmem_timeout}, 32'd0);
            end else begin
                r_got = q_exp.pop_front();
                check("wb_valid",    {31'd0, wb_valid},     {31'd0, r_got.valid});
                check("wb_regwrite", {31'd0, RegWrite_out}, {31'd0, r_got.regwrite});
                check("wb_memtoreg", {31'd0, MemtoReg_out}, {31'd0, r_got.memtoreg});
                check("wb_pc2reg",   {31'd0, PC2Reg_out},   {31'd0, r_got.pc2reg});
                check("wb_funct3",   {29'd0, funct3_out},   {29'd0, r_got.funct3});
                check("wb_rd",       {27'd0, rd_out},       {27'd0, r_got.rd});
                check("wb_rd_data",  rd_data,               r_got.rd_data);
                check("wb_mem_out",  Mem_out,               r_got.mem_out);
                check("wb_misalign", {31'd0, misalign_err}, {31'd0, r_got.mis});
                check("wb_timeout",  {31'd0, dmem_timeout}, {31'd0, r_got.to});
            end
        end
    end

    task automatic drive_op(input op_t op);
        valid_in   = 1'b1;
        MemRead    = op.memread;
        MemWrite   = op.memwrite;
        MemtoReg   = op.memtoreg;
        RegWrite   = op.regwrite;
        PC2Reg     = op.pc2reg;
        funct3     = op.funct3;
        rd_in      = op.rd;
        alu_result = op.alu;
        rs2_data   = op.rs2;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; flush = 1'b0; dmem_ready = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; PC2Reg = 1'b0;
        funct3 = 3'd0; rd_in = 5'd0; alu_result = 32'd0; rs2_data = 32'd0;
        dmem_rdata = 32'd0;
    endtask

    // Holds the instruction until the stage stops stalling; memory answers on
    // cycle ready_at (-1 = never) and flush pulses on cycle flush_at.
    task automatic run_op(input string name, input op_t op, input int ready_at,
                          input int flush_at, input int exp_stalls, input logic exp_req,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] rdata);
        int stalls = 0;
        bit done = 1'b0;
        drive_op(op);
        for (int k = 0; k < 40 && !done; k++) begin
            dmem_ready = (k == ready_at);
            dmem_rdata = dmem_ready ? rdata : 32'hA5A5A5A5;
            flush      = (k == flush_at);
            #1;
            check({name, "_req"}, {31'd0, dmem_req}, {31'd0, exp_req});
            if (exp_req) begin
                check({name, "_we"},    {31'd0, dmem_we}, {31'd0, op.memwrite});
                check({name, "_addr"},  dmem_addr,        exp_addr);
                check({name, "_be"},    {28'd0, dmem_be}, {28'd0, exp_be});
                check({name, "_wdata"}, dmem_wdata,       exp_wdata);
            end
            if (dmem_req && dmem_ready && dmem_we) n_writes++;
            if (stall_out) stalls++;
            else done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check({name, "_stalls"}, stalls, exp_stalls);
        idle_inputs();
    endtask

    initial begin : main
        int w0;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   {31'd0, dmem_req},  32'd0);
        check("rst_stall", {31'd0, stall_out}, 32'd0);
        check("rst_wb", {wb_valid, RegWrite_out, MemtoReg_out, PC2Reg_out, misalign_err,
                         dmem_timeout, funct3_out, rd_out}, 32'd0);
        check("rst_data", rd_data | Mem_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // sw, zero-wait memory
        q_exp.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h104, 32'd0, 1'b0, 1'b0});
        w0 = n_writes;
        run_op("sw", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h104, 32'hDEADBEEF},
               0, -1, 0, 1'b1, 32'h104, 4'b1111, 32'hDEADBEEF, 32'd0);
        check("sw_writes", n_writes - w0, 1);

        // lb with three wait cycles
        q_exp.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 5'd5, 32'h203, 32'h80, 1'b0, 1'b0});
        run_op("lb", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 5'd5, 32'h203, 32'd0},
               3, -1, 3, 1'b1, 32'h200, 4'b1111, 32'd0, 32'h80FF1122);

        // sh to upper half
        q_exp.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 5'd0, 32'h102, 32'd0, 1'b0, 1'b0});
        run_op("sh", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 5'd0, 32'h102, 32'h0000ABCD},
               0, -1, 0, 1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 32'd0);

        // sb to byte 1
        q_exp.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h301, 32'd0, 1'b0, 1'b0});
        run_op("sb", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h301, 32'h123456EF},
               0, -1, 0, 1'b1, 32'h300, 4'b0010, 32'hEFEFEFEF, 32'd0);

        // misaligned lw issues nothing
        q_exp.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd7, 32'h101, 32'd0, 1'b1, 1'b0});
        run_op("lw_mis", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd7, 32'h101, 32'd0},
               0, -1, 0, 1'b0, 32'd0, 4'd0, 32'd0, 32'h11111111);

        // ALU and link-style pass-through
        q_exp.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd9, 32'h12345678, 32'd0, 1'b0, 1'b0});
        run_op("alu", '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd9, 32'h12345678, 32'd0},
               -1, -1, 0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        q_exp.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 5'd1, 32'h44, 32'd0, 1'b0, 1'b0});
        run_op("jal", '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 5'd1, 32'h44, 32'd0},
               -1, -1, 0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);

        // lhu upper half with one wait cycle
        q_exp.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 5'd3, 32'h2, 32'h1234, 1'b0, 1'b0});
        run_op("lhu", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 5'd3, 32'h2, 32'd0},
               1, -1, 1, 1'b1, 32'h0, 4'b1111, 32'd0, 32'h12345678);

        // sw flushed in its second cycle still writes once, retires as bubble
        w0 = n_writes;
        run_op("sw_flush", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h400, 32'hCAFEF00D},
               3, 1, 3, 1'b1, 32'h400, 4'b1111, 32'hCAFEF00D, 32'd0);
        check("flush_writes", n_writes - w0, 1);
        check("flush_wb", {31'd0, wb_valid}, 32'd0);

        // flush in IDLE suppresses the request
        w0 = n_writes;
        run_op("sb_flush", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h500, 32'h55},
               0, 0, 0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        check("idle_flush_writes", n_writes - w0, 0);

        // lw never answered: four stall cycles, then timeout
        q_exp.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd8, 32'h500, 32'd0, 1'b0, 1'b1});
        run_op("lw_to", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd8, 32'h500, 32'd0},
               -1, -1, 4, 1'b1, 32'h500, 4'b1111, 32'd0, 32'd0);
        #1;
        check("to_idle_req", {31'd0, dmem_req}, 32'd0);

        // reset in WAIT with a live entry held in MEM/WB
        q_exp.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd9, 32'h0000BEEF, 32'd0, 1'b0, 1'b0});
        run_op("alu2", '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 5'd9, 32'h0000BEEF, 32'd0},
               -1, -1, 0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        drive_op('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h600, 32'd0});
        @(posedge clk);
        @(negedge clk);
        #1;
        check("wait_req",  {31'd0, dmem_req},  32'd1);
        check("wait_hold", {27'd0, rd_out},    32'd9);
        rst = 1'b1;
        #1;
        check("rstw_req",   {31'd0, dmem_req},  32'd0);
        check("rstw_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        check("rstw_wb", {wb_valid, RegWrite_out, MemtoReg_out, PC2Reg_out, misalign_err,
                          dmem_timeout, funct3_out, rd_out}, 32'd0);
        check("rstw_data", rd_data | Mem_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rstw_idle_req", {31'd0, dmem_req}, 32'd0);
        repeat (2) @(negedge clk);

        check("queue_empty", q_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
